// File: rtl/vp_pkg.sv
// Shared defaults and types for the vp centroid stage.
package vp_pkg;

  localparam int          DEF_H_BITS     = 11;
  localparam int          DEF_V_BITS     = 11;
  localparam int          DEF_SUM_W      = 32;
  localparam int          DEF_CNT_W      = 20;
  localparam logic [7:0]  DEF_THRESH     = 8'd128;
  localparam logic [23:0] DEF_MARK_COLOR = 24'hFF0000;

  // Centroid control: wait for a frame, divide, publish the result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } ctl_state_t;

endpackage

// File: rtl/vp_seq_div.sv
// Radix-2 restoring unsigned divider: one load cycle, then one quotient bit
// per cycle, MSB first. done is a single-cycle pulse; quotient holds its value
// until the next start.
module vp_seq_div
  import vp_pkg::*;
#(
  parameter int SUM_W = DEF_SUM_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [SUM_W-1:0] quotient,
  output logic             done
);

  localparam int CW = $clog2(SUM_W + 1);

  logic [SUM_W-1:0] q;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] dsr;
  logic [CW-1:0]    count;
  logic             busy;

  logic [CNT_W:0]   shifted;
  logic [CNT_W:0]   diff;
  logic             fits;
  logic             unused_diff_msb;

  // Trial subtraction of the divisor from the remainder shifted by one bit.
  always_comb begin
    shifted = {rem, q[SUM_W-1]};
    diff    = shifted - {1'b0, dsr};
    fits    = (shifted >= {1'b0, dsr});
  end

  // The difference is only taken when it fits, so its MSB is always zero.
  assign unused_diff_msb = diff[CNT_W];

  // Load operands on start, then shift one quotient bit in per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      rem   <= '0;
      dsr   <= '0;
      count <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      q     <= dividend;
      rem   <= '0;
      dsr   <= divisor;
      count <= CW'(SUM_W);
      busy  <= 1'b1;
    end else if (busy) begin
      if (count != '0) begin
        q     <= {q[SUM_W-2:0], fits};
        rem   <= fits ? diff[CNT_W-1:0] : shifted[CNT_W-1:0];
        count <= count - CW'(1);
      end else begin
        busy  <= 1'b0;
      end
    end
  end

  assign quotient = q;
  assign done     = busy && (count == '0);

endmodule

// File: rtl/vp_centroid.sv
// Binary-mask centroid of each video frame with a crosshair overlay at the
// most recent valid centroid. Video passes through with one cycle of delay.
//
// Stream contract: the input is a free-running pixel stream with no
// back-pressure; de_in qualifies pixel_in on every cycle it is high, and the
// outputs follow the inputs exactly one clock later.
module vp_centroid
  import vp_pkg::*;
#(
  parameter int          H_BITS     = DEF_H_BITS,
  parameter int          V_BITS     = DEF_V_BITS,
  parameter int          SUM_W      = DEF_SUM_W,
  parameter int          CNT_W      = DEF_CNT_W,
  parameter logic [7:0]  THRESH     = DEF_THRESH,
  parameter logic [23:0] MARK_COLOR = DEF_MARK_COLOR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de_in,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic [23:0]       pixel_in,
  output logic              de_out,
  output logic              h_sync_out,
  output logic              v_sync_out,
  output logic [23:0]       pixel_out,
  output logic [H_BITS-1:0] x_c,
  output logic [V_BITS-1:0] y_c,
  output logic              centroid_valid,
  output logic              centroid_update
);

  ctl_state_t state, state_nx;

  logic              de_q;
  logic              v_q;
  logic              v_rise;
  logic              de_fall;
  logic              fg;
  logic              start;

  logic [H_BITS-1:0] x;
  logic [V_BITS-1:0] y;
  logic [SUM_W-1:0]  sum_x;
  logic [SUM_W-1:0]  sum_y;
  logic [CNT_W-1:0]  cnt;

  logic [SUM_W:0]    sx_add;
  logic [SUM_W:0]    sy_add;
  logic [CNT_W:0]    cnt_add;

  logic [SUM_W-1:0]  quot_x;
  logic [SUM_W-1:0]  quot_y;
  logic              done_x;
  logic              done_y;
  logic              unused_quot;

  assign v_rise  = v_sync_in && !v_q;
  assign de_fall = de_q && !de_in;
  assign fg      = de_in && (pixel_in[7:0] >= THRESH);

  // Widened sums so a carry out can be turned into saturation.
  always_comb begin
    sx_add  = {1'b0, sum_x} + (SUM_W + 1)'(x);
    sy_add  = {1'b0, sum_y} + (SUM_W + 1)'(y);
    cnt_add = {1'b0, cnt} + (CNT_W + 1)'(1);
  end

  // Edge-detect registers for v_sync and de.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q <= 1'b0;
      v_q  <= 1'b0;
    end else begin
      de_q <= de_in;
      v_q  <= v_sync_in;
    end
  end

  // Raster position: x counts active pixels in a line, y counts lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (v_rise) begin
      x <= '0;
      y <= '0;
    end else if (de_fall) begin
      x <= '0;
      y <= y + V_BITS'(1);
    end else if (de_in) begin
      x <= x + H_BITS'(1);
    end
  end

  // Saturating per-frame accumulators; frame end hands them to the dividers
  // (through start) and clears them in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
    end else if (v_rise) begin
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
    end else if (fg) begin
      sum_x <= sx_add[SUM_W] ? '1 : sx_add[SUM_W-1:0];
      sum_y <= sy_add[SUM_W] ? '1 : sy_add[SUM_W-1:0];
      cnt   <= cnt_add[CNT_W] ? '1 : cnt_add[CNT_W-1:0];
    end
  end

  vp_seq_div #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div_x (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (sum_x),
    .divisor  (cnt),
    .quotient (quot_x),
    .done     (done_x)
  );

  vp_seq_div #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div_y (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (sum_y),
    .divisor  (cnt),
    .quotient (quot_y),
    .done     (done_y)
  );

  // Only the low bits of the quotient can be a position inside the frame.
  assign unused_quot = ^{quot_x[SUM_W-1:H_BITS], quot_y[SUM_W-1:V_BITS]};

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state; a frame end while not idle is simply ignored.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (v_rise && (cnt != '0)) begin
          start    = 1'b1;
          state_nx = ST_DIV;
        end
      end
      ST_DIV: begin
        if (done_x && done_y) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign centroid_update = (state == ST_DONE);

  // Publish the centroid while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_c            <= '0;
      y_c            <= '0;
      centroid_valid <= 1'b0;
    end else if (state == ST_DONE) begin
      x_c            <= quot_x[H_BITS-1:0];
      y_c            <= quot_y[V_BITS-1:0];
      centroid_valid <= 1'b1;
    end
  end

  // One-cycle video delay with the crosshair painted over the pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_out     <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
      pixel_out  <= '0;
    end else begin
      de_out     <= de_in;
      h_sync_out <= h_sync_in;
      v_sync_out <= v_sync_in;
      if (centroid_valid && de_in && ((x == x_c) || (y == y_c)))
        pixel_out <= MARK_COLOR;
      else
        pixel_out <= pixel_in;
    end
  end

endmodule

// File: tb/tb_vp_centroid.sv
// Bench for vp_centroid: 64x64 frame generator, frame-level centroid model
// (sums and floor division over the foreground mask) and a per-cycle check of
// the delayed, overlaid video.
module tb_vp_centroid;

  localparam int          FW   = 64;
  localparam int          FH   = 64;
  localparam logic [23:0] MARK = 24'hFF0000;
  localparam int          LAT  = 34;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        de_in, h_sync_in, v_sync_in;
  logic [23:0] pixel_in;
  logic        de_out, h_sync_out, v_sync_out;
  logic [23:0] pixel_out;
  logic [10:0] x_c;
  logic [10:0] y_c;
  logic        centroid_valid, centroid_update;

  vp_centroid dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .de_in           (de_in),
    .h_sync_in       (h_sync_in),
    .v_sync_in       (v_sync_in),
    .pixel_in        (pixel_in),
    .de_out          (de_out),
    .h_sync_out      (h_sync_out),
    .v_sync_out      (v_sync_out),
    .pixel_out       (pixel_out),
    .x_c             (x_c),
    .y_c             (y_c),
    .centroid_valid  (centroid_valid),
    .centroid_update (centroid_update)
  );

  // Clock
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bit fg_mask [FH][FW];
  bit no_red;

  // Scoreboard of expected {x_c, y_c} per accepted frame end.
  logic [21:0] exp_q[$];

  // Frame-level reference model.
  longint      m_sx, m_sy, m_cnt;
  bit          m_prev_vs;
  bit          m_have_acc;
  int          m_acc_cyc;
  logic [10:0] m_xc, m_yc;
  bit          m_valid;
  bit          chk_next;
  logic [21:0] pend_val;
  int          upd_total;
  int          mark_cnt;

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_cnt = 0;
    m_prev_vs = 1'b0; m_have_acc = 1'b0; m_acc_cyc = 0;
    m_xc = '0; m_yc = '0; m_valid = 1'b0;
    chk_next = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_frame_end();
    logic [10:0] ex, ey;
    int edge_idx;
    edge_idx = cyc + 1;
    if (!(m_have_acc && (edge_idx - m_acc_cyc) <= LAT) && m_cnt != 0) begin
      ex = 11'(m_sx / m_cnt);
      ey = 11'(m_sy / m_cnt);
      exp_q.push_back({ex, ey});
      m_have_acc = 1'b1;
      m_acc_cyc  = edge_idx;
    end
    m_sx = 0; m_sy = 0; m_cnt = 0;
  endtask

  function automatic logic [23:0] gen_pix(bit fg);
    logic [23:0] p;
    p[23:8] = 16'($urandom);
    if (no_red) p[23] = 1'b0;
    if (fg) p[7:0] = ($urandom_range(3, 0) == 0) ? 8'd128 : 8'($urandom_range(255, 128));
    else    p[7:0] = ($urandom_range(3, 0) == 0) ? 8'd127 : 8'($urandom_range(127, 0));
    return p;
  endfunction

  // Driver: one clock of input, then check the delayed video and the
  // centroid outputs against the model.
  task automatic drive_cycle(input logic de, input logic hs, input logic vs,
                             input logic [23:0] pix, input int col, input int row);
    logic [23:0] exp_pix;
    if (vs && !m_prev_vs) model_frame_end();
    else if (de && pix[7:0] >= 8'd128) begin
      m_sx += col; m_sy += row; m_cnt += 1;
    end
    m_prev_vs = vs;
    exp_pix = (m_valid && de && (col == int'(m_xc) || row == int'(m_yc))) ? MARK : pix;
    de_in = de; h_sync_in = hs; v_sync_in = vs; pixel_in = pix;
    @(posedge clk);
    cyc++;
    #1;
    n_vec++;
    if ({de_out, h_sync_out, v_sync_out} !== {de, hs, vs}) begin
      n_err++;
      $display("FAIL sync_delay cyc=%0d got=%b want=%b", cyc,
               {de_out, h_sync_out, v_sync_out}, {de, hs, vs});
    end
    n_vec++;
    if (pixel_out !== exp_pix) begin
      n_err++;
      $display("FAIL pixel_out cyc=%0d col=%0d row=%0d got=%h want=%h", cyc, col, row,
               pixel_out, exp_pix);
    end
    if (de_out && pixel_out === MARK) mark_cnt++;
    if (chk_next) begin
      n_vec++;
      if ({x_c, y_c, centroid_valid} !== {pend_val, 1'b1}) begin
        n_err++;
        $display("FAIL centroid_load got x=%0d y=%0d v=%b want x=%0d y=%0d v=1", x_c, y_c,
                 centroid_valid, pend_val[21:11], pend_val[10:0]);
      end
      m_xc = pend_val[21:11]; m_yc = pend_val[10:0]; m_valid = 1'b1;
      chk_next = 1'b0;
    end
    if (centroid_update === 1'b1) begin
      upd_total++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_update cyc=%0d got=1 want=0", cyc);
      end else begin
        pend_val = exp_q.pop_front();
        chk_next = 1'b1;
        n_vec++;
        if ((cyc - m_acc_cyc) > LAT || (cyc - m_acc_cyc) < 1) begin
          n_err++;
          $display("FAIL update_latency got=%0d want<=%0d", cyc - m_acc_cyc, LAT);
        end
      end
    end
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 24'h0, -1, -1);
  endtask

  task automatic run_rows(input int r0, input int r1);
    for (int r = r0; r <= r1; r++) begin
      for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b1, 1'b0, 24'h0, -1, -1);
      blank(2);
      for (int c = 0; c < FW; c++) drive_cycle(1'b1, 1'b0, 1'b0, gen_pix(fg_mask[r][c]), c, r);
      blank(4);
    end
  endtask

  task automatic do_vsync();
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b1, 24'h0, -1, -1);
    blank(40);
  endtask

  task automatic clear_mask();
    foreach (fg_mask[r, c]) fg_mask[r][c] = 1'b0;
  endtask

  task automatic check_xy(input string name, input int ex, input int ey, input bit ev);
    n_vec++;
    if (x_c !== 11'(ex) || y_c !== 11'(ey) || centroid_valid !== ev) begin
      n_err++;
      $display("FAIL %s got x=%0d y=%0d v=%b want x=%0d y=%0d v=%b", name, x_c, y_c,
               centroid_valid, ex, ey, ev);
    end
  endtask

  task automatic check_updates(input string name, input int got, input int want);
    n_vec++;
    if (got != want || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s got=%0d updates want=%0d pending=%0d", name, got, want, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0; pixel_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({de_out, h_sync_out, v_sync_out, pixel_out, x_c, y_c, centroid_valid,
         centroid_update} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h want=0", {de_out, h_sync_out, v_sync_out,
               pixel_out, x_c, y_c, centroid_valid, centroid_update});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int u0;
    clear_mask();
    fg_mask[5][10] = 1'b1;
    run_rows(0, FH - 1);
    u0 = upd_total;
    do_vsync();
    check_updates("single_update_count", upd_total - u0, 1);
    check_xy("single_centroid", 10, 5, 1'b1);
  endtask

  task automatic test_block();
    int u0;
    clear_mask();
    for (int r = 30; r <= 33; r++)
      for (int c = 20; c <= 23; c++) fg_mask[r][c] = 1'b1;
    run_rows(0, FH - 1);
    u0 = upd_total;
    do_vsync();
    check_updates("block_update_count", upd_total - u0, 1);
    check_xy("block_centroid", 21, 31, 1'b1);
  endtask

  task automatic test_empty();
    int u0;
    clear_mask();
    run_rows(0, FH - 1);
    u0 = upd_total;
    do_vsync();
    check_updates("empty_no_update", upd_total - u0, 0);
    check_xy("empty_held", 21, 31, 1'b1);
  endtask

  task automatic test_overlay();
    clear_mask();
    no_red = 1'b1;
    mark_cnt = 0;
    run_rows(0, FH - 1);
    no_red = 1'b0;
    n_vec++;
    if (mark_cnt != FW + FH - 1) begin
      n_err++;
      $display("FAIL overlay_mark_count got=%0d want=%0d", mark_cnt, FW + FH - 1);
    end
    do_vsync();
  endtask

  task automatic test_reset_mid();
    int u0;
    clear_mask();
    fg_mask[3][3] = 1'b1;
    run_rows(0, 29);
    for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b1, 1'b0, 24'h0, -1, -1);
    blank(2);
    for (int c = 0; c < 20; c++) drive_cycle(1'b1, 1'b0, 1'b0, gen_pix(1'b0), c, 30);
    rst_n = 1'b0;
    de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0; pixel_in = '0;
    #1;
    n_vec++;
    if ({de_out, h_sync_out, v_sync_out, pixel_out, x_c, y_c, centroid_valid,
         centroid_update} !== '0) begin
      n_err++;
      $display("FAIL midframe_reset_outputs got=%h want=0", {de_out, h_sync_out, v_sync_out,
               pixel_out, x_c, y_c, centroid_valid, centroid_update});
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 20; c < FW; c++) drive_cycle(1'b1, 1'b0, 1'b0, gen_pix(1'b0), -1, -1);
    blank(4);
    run_rows(31, FH - 1);
    u0 = upd_total;
    do_vsync();
    check_updates("partial_frame_no_update", upd_total - u0, 0);
    check_xy("after_reset_cleared", 0, 0, 1'b0);
    clear_mask();
    fg_mask[9][7] = 1'b1;
    run_rows(0, FH - 1);
    u0 = upd_total;
    do_vsync();
    check_updates("post_reset_update_count", upd_total - u0, 1);
    check_xy("post_reset_centroid", 7, 9, 1'b1);
  endtask

  task automatic test_back_to_back();
    int u0;
    clear_mask();
    fg_mask[50][40] = 1'b1;
    run_rows(0, FH - 1);
    u0 = upd_total;
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b1, 24'h0, -1, -1);
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b0, 1'b0, gen_pix(1'b1), i, 0);
    do_vsync();
    check_updates("back_to_back_one_update", upd_total - u0, 1);
    check_xy("back_to_back_first_result", 40, 50, 1'b1);
  endtask

  task automatic test_random();
    int u0;
    for (int f = 0; f < 3; f++) begin
      foreach (fg_mask[r, c]) begin
        case (f)
          0:       fg_mask[r][c] = ($urandom_range(31, 0) == 0);
          1:       fg_mask[r][c] = $urandom_range(1, 0) == 1;
          default: fg_mask[r][c] = 1'b1;
        endcase
      end
      run_rows(0, FH - 1);
      u0 = upd_total;
      do_vsync();
      check_updates("random_update_count", upd_total - u0, 1);
      check_xy("random_centroid", int'(m_xc), int'(m_yc), 1'b1);
    end
  endtask

  initial begin
    no_red = 1'b0;
    upd_total = 0;
    mark_cnt = 0;
    test_reset();
    test_single();
    test_block();
    test_empty();
    test_overlay();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vp_centroid.md
Name: vp_centroid

Overview:
- Video-path stage directly downstream of the vp processing block; consumes its de/h_sync/v_sync/pixel stream.
- Treats each pixel as a binary mask value and accumulates per-frame x/y sums and a foreground count.
- At frame end, divides sequentially to produce the object centroid, then overlays a crosshair at the last valid centroid on the passed-through video.
- Output feeds the HDMI/display output stage.

Parameters:
- H_BITS, 11, width of column counter and x_c.
- V_BITS, 11, width of row counter and y_c.
- SUM_W, 32, width of sum_x/sum_y accumulators; dividend width.
- CNT_W, 20, width of foreground-pixel counter; divisor width.
- THRESH, 8'd128, pixel is foreground when pixel_in[7:0] >= THRESH.
- MARK_COLOR, 24'hFF0000, crosshair colour.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- de_in  in  1  data enable from vp.
- h_sync_in  in  1  horizontal sync from vp.
- v_sync_in  in  1  vertical sync from vp.
- pixel_in  in  24  RGB pixel from vp.
- de_out  out  1  de_in delayed 1 cycle.
- h_sync_out  out  1  h_sync_in delayed 1 cycle.
- v_sync_out  out  1  v_sync_in delayed 1 cycle.
- pixel_out  out  24  pixel_in delayed 1 cycle, crosshair applied.
- x_c  out  H_BITS  centroid column.
- y_c  out  V_BITS  centroid row.
- centroid_valid  out  1  level; set after first successful centroid, cleared only by reset.
- centroid_update  out  1  1-cycle pulse when x_c/y_c load new values.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; counters, accumulators, edge registers 0; divider FSM IDLE.
- Position: x increments each cycle de_in=1; x clears on de_in falling edge. y increments on de_in falling edge. x and y both clear on v_sync_in rising edge.
- Accumulate: when de_in=1 and pixel_in[7:0] >= THRESH: sum_x += x, sum_y += y, cnt += 1. Accumulators saturate at all-ones; they do not wrap.
- Frame end: v_sync_in rising edge, detected with one registered sample.
  - Latch sum_x, sum_y, cnt into divider operands.
  - Clear accumulators in the same cycle.
- Control FSM:
  - IDLE -> DIV: on frame end with cnt != 0 and FSM idle.
  - IDLE stays IDLE: on frame end with cnt == 0. No update, x_c/y_c held.
  - DIV -> DONE: when both dividers assert done.
  - DONE -> IDLE: next cycle. In DONE, x_c <= quot_x[H_BITS-1:0], y_c <= quot_y[V_BITS-1:0], centroid_update=1, centroid_valid <= 1.
- Frame end while in DIV: that frame's data is discarded; accumulators still clear; current division completes undisturbed.
- Division: quotient = floor(sum/cnt), unsigned. Latency from frame-end cycle to centroid_update = SUM_W+2 cycles (34 at defaults). Blanking must exceed this; it is not checked.
- Overlay, registered, 1-cycle latency:
  - When centroid_valid=1 and de_in=1 and (x == x_c or y == y_c): pixel_out = MARK_COLOR.
  - Otherwise pixel_out = pixel_in.
  - Syncs and de pass through the same 1-stage delay, so alignment is preserved.
- Reset mid-frame: everything clears; the next v_sync rising edge starts a clean frame. A partial first frame after reset is accumulated normally.

Decomposition:
- Package vp_pkg: H_BITS/V_BITS/SUM_W/CNT_W defaults, FSM state enum (IDLE, DIV, DONE), MARK_COLOR default.
- Sub-module vp_seq_div: radix-2 restoring unsigned divider.
  - Ports: clk, rst_n, start, dividend[SUM_W], divisor[CNT_W], quotient[SUM_W], done.
  - SUM_W iterations plus 1 load cycle.
- Two instances (x, y) run in parallel.

Test Plan:
- Bench uses a 64x64 active frame generator. Rule for all scenarios: one frame end yields at most one centroid_update.
- Single foreground pixel at (10,5), all others 0 -> after v_sync rise, centroid_update within 34 cycles; x_c=10, y_c=5; centroid_valid=1.
- Foreground block x 20..23, y 30..33 (16 px) -> x_c=21 (344/16 truncated), y_c=31.
- Empty frame after the previous test -> no centroid_update; x_c=21, y_c=31 held.
- Overlay with x_c=21, y_c=31 -> every active pixel in column 21 and row 31 reads 24'hFF0000 one cycle after input; other pixels equal input delayed 1 cycle; de/h/v_sync outputs match inputs delayed 1.
- Assert rst_n=0 mid-frame for 3 cycles -> all outputs 0 immediately; next full frame with pixel at (7,9) gives x_c=7, y_c=9.
- Two v_sync rises 10 cycles apart (second during DIV) -> exactly one centroid_update, carrying the first frame's result.
